video_pll_lock_sequencer: RTL
=============================

// Module: video_pll_lock_sequencer
// PURPOSE
//  Sequences bring-up and recovery of the video PLL in the refclk (50 MHz) domain.
//  - Drives the PLL reset and watches its asynchronous locked output.
//  - Retries on lock timeout and enters FAULT after repeated failures.
//  - Releases downstream video logic only after lock has been continuously stable.
//  - Sits between board reset and the PLL/VGA timing logic.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_rst is held high per attempt (>=1)
//  STABLE_CYCLES  1024   consecutive synced-locked cycles required before RUN (>=1)
//  LOCK_TIMEOUT   65536  cycles in WAIT_LOCK before an attempt counts as failed (>=1)
//  MAX_RETRIES    3      failed attempts (timeouts or STABLE drops) before FAULT (>=1)
//  CNT_W          8      width of loss_count
// PORTS
//  refclk      in   1      single clock; all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  pll_locked  in   1      PLL locked; asynchronous, double-flop synchronised internally
//  retry_req   in   1      one-cycle pulse; leaves FAULT and restarts sequencing
//  pll_rst     out  1      reset to PLL, active-high
//  video_rst   out  1      reset to downstream video logic, active-high
//                          refclk domain; consumers resynchronise
//  pll_ready   out  1      high only in RUN
//  fault       out  1      high only in FAULT
//  loss_count  out  CNT_W  lock-loss events seen in RUN; saturating
//  state       out  3      RESET=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAULT=4
// BEHAVIOUR
//  Synchronous reset (rst=1):
//   - state=RESET, pll_rst=1, video_rst=1, pll_ready=0, fault=0, loss_count=0.
//   - Attempt counter, cycle counter and both sync flops are cleared.
//   - rst wins over every other event, including mid-RUN; outputs reset on the next edge.
//  Synchronisation: locked_s = pll_locked after 2 flops (2-cycle latency).
//  Outputs: all registered and decoded from the next state, so they change on
//   the same edge as state.
//   - pll_rst=1 in RESET and FAULT.
//   - video_rst = ~(state==RUN).
//  Shared cycle counter cnt; cleared on every state transition.
//  RESET:
//   - When cnt==RST_CYCLES-1 -> WAIT_LOCK.
//  WAIT_LOCK:
//   - If locked_s -> STABLE.
//   - Else if cnt==LOCK_TIMEOUT-1: attempts++; -> FAULT if attempts reaches
//     MAX_RETRIES, else -> RESET.
//  STABLE:
//   - If !locked_s: attempts++; -> FAULT if attempts reaches MAX_RETRIES, else -> RESET.
//   - Else if cnt==STABLE_CYCLES-1 -> RUN and attempts cleared.
//  RUN:
//   - If !locked_s: -> RESET; loss_count++ (holds at 2^CNT_W-1); attempts not incremented.
//  FAULT:
//   - Held indefinitely.
//   - retry_req=1 -> RESET with attempts cleared; loss_count is preserved.
//   - retry_req outside FAULT is ignored.
// TESTING
//  Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2, CNT_W=2.
//  Cycle 0 is the first edge with rst=0.
//  1. pll_locked=1 throughout.
//     -> pll_rst=1 cycles 0-3, 0 from cycle 4.
//     -> state 1 at cycle 4, 2 at cycle 5, 3 at cycle 13.
//     -> pll_ready=1 and video_rst=0 from cycle 13.
//  2. pll_locked=0 throughout.
//     -> first timeout at cycle 35, RESET again.
//     -> second timeout -> fault=1, pll_rst=1, stays high.
//     -> retry_req pulse -> state=0, fault=0 on the next edge.
//  3. In RUN, drop pll_locked at cycle N.
//     -> state=0, pll_ready=0, video_rst=1 at cycle N+3; loss_count=1.
//     -> with lock restored, RUN is regained after a full resequence.
//  4. In STABLE, 1-cycle low glitch on pll_locked after 5 stable cycles.
//     -> RESET, attempt consumed, no RUN entry.
//     -> a second glitch in the next STABLE -> FAULT.
//  5. Cause 5 lock losses in RUN -> loss_count reads 1,2,3,3,3 (saturation).
//  6. Assert rst for 1 cycle while in RUN with loss_count=2.
//     -> next edge: state=0, pll_rst=1, video_rst=1, pll_ready=0, loss_count=0.

Source files
------------

// File: rtl/video_pll_lock_sequencer.sv
// Video PLL bring-up/recovery sequencer in the refclk domain: drives pll_rst,
// retries on lock timeout, and releases video logic only after sustained lock.
module video_pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             retry_req,
  output logic             pll_rst,
  output logic             video_rst,
  output logic             pll_ready,
  output logic             fault,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned AW      = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    att_q, att_d, att_inc;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             sync1_q, sync2_q;
  logic             pll_rst_q, video_rst_q, pll_ready_q, fault_q;
  logic             locked_s;

  assign locked_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    att_d   = att_q;
    att_inc = att_q + 1'b1;
    loss_d  = loss_q;
    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          att_d   = att_inc;
          state_d = (att_inc == ATT_MAX) ? ST_FAULT : ST_RESET;
        end
      end
      ST_STABLE: begin
        // Losing lock takes priority over completing the stability window.
        if (!locked_s) begin
          att_d   = att_inc;
          state_d = (att_inc == ATT_MAX) ? ST_FAULT : ST_RESET;
        end else if (cnt_q == STB_LAST) begin
          att_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RESET;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (retry_req) begin
          att_d   = '0;
          state_d = ST_RESET;
        end
      end
      default: state_d = ST_RESET;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode state_d so they update on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      att_q       <= '0;
      loss_q      <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      pll_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      att_q       <= att_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      video_rst_q <= (state_d != ST_RUN);
      pll_ready_q <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign video_rst  = video_rst_q;
  assign pll_ready  = pll_ready_q;
  assign fault      = fault_q;
  assign loss_count = loss_q;
  assign state      = state_q;

endmodule
